// File: rtl/alto_shifter_pkg.sv
// Shared encodings for the sequential Alto shifter: operation codes and FSM states.
package alto_shifter_pkg;

    localparam int unsigned SHOP_W  = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [SHOP_W-1:0] {
        SHOP_LSH = 2'd0,
        SHOP_RSH = 2'd1,
        SHOP_LCY = 2'd2,
        SHOP_RCY = 2'd3
    } shop_e;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/alto_shifter_step.sv
// One-bit shift/rotate step with MAGIC fill from T and DNS carry chaining.
module alto_shifter_step
    import alto_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] tw_i,
    input  logic             c_i,
    input  shop_e            op_i,
    input  logic             magic_i,
    input  logic             dns_i,
    output logic [WIDTH-1:0] a_c_o,
    output logic [WIDTH-1:0] tw_c_o,
    output logic             c_c_o
);

    always_comb begin
        a_c_o  = a_i;
        tw_c_o = tw_i;
        c_c_o  = c_i;
        case (op_i)
            SHOP_LSH: begin
                // DNS carry is OR-ed into the bit that becomes the new MSB
                a_c_o  = {a_i[WIDTH-2] | (dns_i & c_i), a_i[WIDTH-3:0], magic_i & tw_i[WIDTH-1]};
                tw_c_o = {tw_i[WIDTH-2:0], 1'b0};
                if (dns_i) c_c_o = a_i[WIDTH-1];
            end
            SHOP_RSH: begin
                a_c_o  = {magic_i & tw_i[0], a_i[WIDTH-1:2], a_i[1] | (dns_i & c_i)};
                tw_c_o = {1'b0, tw_i[WIDTH-1:1]};
                if (dns_i) c_c_o = a_i[0];
            end
            SHOP_LCY: a_c_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
            SHOP_RCY: a_c_o = {a_i[0], a_i[WIDTH-1:1]};
            default: ;
        endcase
    end

endmodule

// File: rtl/alto_shifter_seq.sv
// Multi-cycle shifter: one bit step per clock, start/done handshake, registered results.
module alto_shifter_seq
    import alto_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [SHOP_W-1:0] op_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              magic_i,
    input  logic              dns_i,
    input  logic              dns_carry_i,
    input  logic [WIDTH-1:0]  input_i,
    input  logic [WIDTH-1:0]  t_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  result_o,
    output logic              dns_carry_o
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, tw_q, tw_d, result_q, result_d;
    logic               c_q, c_d, carry_q, carry_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    shop_e              op_q, op_d;
    logic               magic_q, magic_d, dns_q, dns_d;
    logic               done_q, done_d, ready_q, ready_d, busy_q, busy_d;
    logic [WIDTH-1:0]   step_a_c, step_tw_c;
    logic               step_c_c;
    logic               accept_c;

    alto_shifter_step #(.WIDTH(WIDTH)) u_step (
        .a_i     (a_q),
        .tw_i    (tw_q),
        .c_i     (c_q),
        .op_i    (op_q),
        .magic_i (magic_q),
        .dns_i   (dns_q),
        .a_c_o   (step_a_c),
        .tw_c_o  (step_tw_c),
        .c_c_o   (step_c_c)
    );

    assign accept_c = start_i && (state_q != S_SHIFT);

    // Next-state, datapath and output logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        tw_d     = tw_q;
        c_d      = c_q;
        rem_d    = rem_q;
        op_d     = op_q;
        magic_d  = magic_q;
        dns_d    = dns_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = (state_q == S_DONE);
        if (state_q == S_DONE) begin
            result_d = a_q;
            carry_d  = c_q;
        end
        case (state_q)
            S_SHIFT: begin
                a_d   = step_a_c;
                tw_d  = step_tw_c;
                c_d   = step_c_c;
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        if (accept_c) begin
            a_d     = input_i;
            tw_d    = t_i;
            c_d     = dns_carry_i;
            rem_d   = count_i;
            op_d    = shop_e'(op_i);
            magic_d = magic_i;
            dns_d   = dns_i;
            state_d = (count_i != '0) ? S_SHIFT : S_DONE;
        end
        ready_d = (state_d != S_SHIFT);
        busy_d  = (state_d == S_SHIFT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            tw_q     <= '0;
            c_q      <= 1'b0;
            rem_q    <= '0;
            op_q     <= SHOP_LSH;
            magic_q  <= 1'b0;
            dns_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            tw_q     <= tw_d;
            c_q      <= c_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            magic_q  <= magic_d;
            dns_q    <= dns_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign dns_carry_o = carry_q;

endmodule
